// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-side constants: default widths and the canonical RISC-V NOP.
// Also a helper for sizing occupancy counters.
package if_fetch_buffer_pkg;

    localparam int          RV_PC_WIDTH    = 32;
    localparam int          RV_IMEM_AWIDTH = 14;
    localparam int          RV_INST_WIDTH  = 32;
    localparam logic [31:0] RV_NOP_INST    = 32'h0000_0013;

    // An occupancy counter for a buffer of `depth` entries must also represent "full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// The head entry is presented combinationally from storage.
module if_fetch_buffer_sync_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Guard against popping empty or pushing full (a simultaneous pop frees the slot first)
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r < CNT_W'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues PC reads to a 1-cycle BRAM, buffers {pc, inst}
// pairs and hands them to decode; credit-based back-pressure to the PC register.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int          PC_WIDTH    = RV_PC_WIDTH,
    parameter int          IMEM_AWIDTH = RV_IMEM_AWIDTH,
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [31:0] NOP_INST    = RV_NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   redirect_in,
    input  logic [31:0]            imem_dout_in,
    input  logic                   id_ready_in,
    output logic [IMEM_AWIDTH-1:0] imem_addr_out,
    output logic                   imem_en_out,
    output logic                   pc_hold_out,
    output logic                   id_valid_out,
    output logic [31:0]            id_inst_out,
    output logic [PC_WIDTH-1:0]    id_pc_out
);

    localparam int             CNT_W   = cnt_width(FIFO_DEPTH);
    localparam int             ENTRY_W = PC_WIDTH + RV_INST_WIDTH;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    logic                inflight_r;
    logic [PC_WIDTH-1:0] inflight_pc_r;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_head_s;
    logic [CNT_W:0]      occ_s;
    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic                unused_pc_bits_s;

    // Credit check: a read may issue only if its return is guaranteed a FIFO slot
    always_comb begin
        pop_s   = !fifo_empty_s && id_ready_in;
        occ_s   = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        issue_s = !rst && !redirect_in && (occ_s < DEPTH_V);
        push_s  = inflight_r && !redirect_in;
    end

    // Track the single outstanding BRAM read and the PC it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_WIDTH{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_in;
            end
        end
    end

    if_fetch_buffer_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_in),
        .din   ({inflight_pc_r, imem_dout_in}),
        .dout  (fifo_head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign imem_addr_out    = pc_in[IMEM_AWIDTH+1:2];
    assign imem_en_out      = issue_s;
    assign pc_hold_out      = !issue_s && !redirect_in;
    assign unused_pc_bits_s = ^{pc_in[PC_WIDTH-1:IMEM_AWIDTH+2], pc_in[1:0]};

    // Decode sees a NOP at PC 0 whenever the buffer is empty
    always_comb begin
        id_valid_out = !fifo_empty_s;
        id_inst_out  = NOP_INST;
        id_pc_out    = {PC_WIDTH{1'b0}};
        if (!fifo_empty_s) begin
            id_inst_out = fifo_head_s[RV_INST_WIDTH-1:0];
            id_pc_out   = fifo_head_s[ENTRY_W-1:RV_INST_WIDTH];
        end else begin
            id_inst_out = NOP_INST;
            id_pc_out   = {PC_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a PC-register model, a 1-cycle BRAM
// model and an in-order scoreboard on every decode handshake.
module tb_if_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        redirect_in;
    logic [31:0] imem_dout_in;
    logic        id_ready_in;
    logic [13:0] imem_addr_out;
    logic        imem_en_out;
    logic        pc_hold_out;
    logic        id_valid_out;
    logic [31:0] id_inst_out;
    logic [31:0] id_pc_out;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;
    logic [31:0] target;
    bit          no_hold;

    if_fetch_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .redirect_in   (redirect_in),
        .imem_dout_in  (imem_dout_in),
        .id_ready_in   (id_ready_in),
        .imem_addr_out (imem_addr_out),
        .imem_en_out   (imem_en_out),
        .pc_hold_out   (pc_hold_out),
        .id_valid_out  (id_valid_out),
        .id_inst_out   (id_inst_out),
        .id_pc_out     (id_pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bram(input logic [13:0] a);
        return {a, 18'h1_2345};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check any handshake, then advance the PC and BRAM models
    task automatic step();
        logic        hold_v;
        logic        red_v;
        logic [13:0] addr_v;
        if (id_valid_out && id_ready_in) begin
            chk("pop_pc", id_pc_out, exp_pc);
            chk("pop_inst", id_inst_out, bram(exp_pc[15:2]));
            exp_pc = exp_pc + 32'd4;
        end
        if (no_hold) chk("no_hold", {31'd0, pc_hold_out}, 32'd0);
        hold_v = pc_hold_out;
        red_v  = redirect_in;
        addr_v = imem_addr_out;
        @(posedge clk);
        #1;
        imem_dout_in = bram(addr_v);
        if (rst) begin
            pc_in  = 32'd0;
            exp_pc = 32'd0;
        end else if (red_v) begin
            pc_in  = target;
            exp_pc = target;
        end else if (!hold_v) begin
            pc_in = pc_in + 32'd4;
        end
        redirect_in = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'd0; redirect_in = 1'b0; imem_dout_in = 32'd0;
        id_ready_in = 1'b1; exp_pc = 32'd0; target = 32'd0; no_hold = 1'b0;
        #2;
        chk("reset_valid", {31'd0, id_valid_out}, 32'd0);
        chk("reset_inst", id_inst_out, 32'h0000_0013);
        chk("reset_pc", id_pc_out, 32'd0);
        chk("reset_en", {31'd0, imem_en_out}, 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("first_en", {31'd0, imem_en_out}, 32'd1);
        chk("first_addr", {18'd0, imem_addr_out}, 32'd0);
        chk("first_hold", {31'd0, pc_hold_out}, 32'd0);
        no_hold = 1'b1;
        step();
        chk("t1_valid", {31'd0, id_valid_out}, 32'd0);
        step();
        chk("t2_valid", {31'd0, id_valid_out}, 32'd1);
        chk("t2_pc", id_pc_out, 32'd0);
        repeat (8) step();
        chk("stream_head", id_pc_out, 32'd32);

        // Decode stalls for four cycles
        no_hold = 1'b0;
        id_ready_in = 1'b0;
        #1;
        chk("stall_en0", {31'd0, imem_en_out}, 32'd0);
        chk("stall_hold0", {31'd0, pc_hold_out}, 32'd1);
        repeat (4) step();
        chk("stall_count", {30'd0, dut.fifo_count_s}, 32'd2);
        chk("stall_valid", {31'd0, id_valid_out}, 32'd1);
        chk("stall_hold", {31'd0, pc_hold_out}, 32'd1);
        chk("stall_en", {31'd0, imem_en_out}, 32'd0);
        chk("stall_pc", id_pc_out, 32'd32);
        id_ready_in = 1'b1;
        #1;
        chk("resume_en", {31'd0, imem_en_out}, 32'd1);
        no_hold = 1'b1;
        repeat (6) step();
        chk("resume_head", id_pc_out, 32'd56);

        // Redirect from steady state (one buffered, one in flight)
        target = 32'h100;
        redirect_in = 1'b1;
        #1;
        chk("redir_en", {31'd0, imem_en_out}, 32'd0);
        chk("redir_hold", {31'd0, pc_hold_out}, 32'd0);
        step();
        chk("redir_valid1", {31'd0, id_valid_out}, 32'd0);
        step();
        chk("redir_valid2", {31'd0, id_valid_out}, 32'd0);
        step();
        chk("redir_valid3", {31'd0, id_valid_out}, 32'd1);
        chk("redir_pc", id_pc_out, 32'h100);
        repeat (4) step();
        chk("redir_head", id_pc_out, 32'h110);

        // Redirect with a full buffer and decode stalled
        no_hold = 1'b0;
        id_ready_in = 1'b0;
        #1;
        repeat (3) step();
        chk("full_count", {30'd0, dut.fifo_count_s}, 32'd2);
        target = 32'h200;
        redirect_in = 1'b1;
        #1;
        chk("fr_hold", {31'd0, pc_hold_out}, 32'd0);
        chk("fr_en", {31'd0, imem_en_out}, 32'd0);
        step();
        chk("fr_valid", {31'd0, id_valid_out}, 32'd0);
        chk("fr_count", {30'd0, dut.fifo_count_s}, 32'd0);
        id_ready_in = 1'b1;
        #1;
        step(); step();
        chk("fr_valid2", {31'd0, id_valid_out}, 32'd1);
        chk("fr_pc", id_pc_out, 32'h200);
        no_hold = 1'b1;
        repeat (4) step();
        chk("fr_head", id_pc_out, 32'h210);

        // Decode ready toggles every cycle
        no_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            id_ready_in = i[0];
            #1;
            chk("toggle_count_le2", {31'd0, (dut.fifo_count_s <= 2'd2)}, 32'd1);
            step();
        end
        id_ready_in = 1'b1;
        #1;
        repeat (4) step();

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, id_valid_out}, 32'd0);
        chk("rst_inst", id_inst_out, 32'h0000_0013);
        chk("rst_pc", id_pc_out, 32'd0);
        chk("rst_en", {31'd0, imem_en_out}, 32'd0);
        chk("rst_count", {30'd0, dut.fifo_count_s}, 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        no_hold = 1'b1;
        step(); step();
        chk("rst_rel_valid", {31'd0, id_valid_out}, 32'd1);
        chk("rst_rel_pc", id_pc_out, 32'd0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
